c3540_alu_core: RTL and testbench
=================================

// Module: c3540_alu_core
// PURPOSE
//   8-bit ALU/control core, modelled on the ISCAS-85 c3540 function class: binary/BCD add-sub,
//   logic, shift/rotate, pass/mux ops, plus an always-on equality datapath. Flat 50-bit input
//   vector, 22-bit output vector, one registered pipeline stage. Used as the golden model
//   beside its gate-level netlist twin in fault-simulation / random-test-generation benches.
// PARAMETERS
//   none (all widths fixed: 50 in, 22 out)
// PORTS
//   clk      in   1   single clock; all state updates on posedge
//   rst      in   1   synchronous, active-high reset
//   in_vec   in   50  a=[7:0] b=[15:8] c=[23:16] op=[27:24] cin=[28] bcd=[29] en=[30]; [49:31] reserved
//   out_vec  out  22  result=[7:0] eqmask=[15:8] carry=[16] zero=[17] sign=[18] ovf=[19] par=[20] eq=[21]
// BEHAVIOUR
//   - Reset: rst=1 at posedge -> out_vec=22'h0 next cycle; reset wins over en, also mid-stream.
//   - Latency 1: out_vec at edge N+1 reflects in_vec sampled at edge N when en=1; en=0 holds out_vec.
//   - Reserved bits [49:31] never affect out_vec.
//   - op (binary path, bcd=0; sums 9-bit, carry=bit8):
//     0 ADD a+b+cin | 1 SUB a+~b+cin (cin=1 = true subtract, carry=1 means no borrow)
//     2 INC a+1 | 3 DEC a+8'hFF (carry per 9-bit sum) | 4 AND | 5 OR | 6 XOR | 7 NOT a
//     8 SHL {a[6:0],cin}, carry=a[7] | 9 SHR {cin,a[7:1]}, carry=a[0]
//     10 ROL {a[6:0],a[7]}, carry=a[7] | 11 ROR {a[0],a[7:1]}, carry=a[0]
//     12 PASS a | 13 PASS b | 14 MUX (c&b)|(~c&a) bitwise | 15 CMP: result=a, flags from a+~b+1
//   - bcd=1 affects op 0/1 only: op1 first replaces b per nibble by 9-n (nibble>9 -> 4'h0).
//     Low nibble s=a_lo+b_lo+cin; if s>9: s+=6, c4=1. High nibble same with c4; its decimal carry -> carry.
//     Invalid digits (>9) processed by the same algorithm, no error. ovf=0 in BCD mode.
//   - carry=0 for ops 4-7, 12-14. ovf: signed overflow for ops 0-3,15 (binary); 0 otherwise.
//   - zero=(result==0) except CMP: zero=(a==b). sign=result[7] (CMP: diff[7]).
//   - par = ^result (1 when odd count of ones).
//   - eqmask=~(a^b), eq=(a==b): computed every enabled cycle regardless of op/bcd.
//   - Purely combinational decode feeding one 22-bit register; no other state, no X on outputs.
// TESTING
//   rst=1 2 cycles, then en=0 any input -> out_vec==0 held.
//   ADD bin a=7F b=01 cin=0 en=1 -> result=80 carry=0 ovf=1 sign=1 zero=0 par=1 eq=0.
//   SUB bin a=10 b=10 cin=1 -> result=00 carry=1 zero=1 eq=1 eqmask=FF ovf=0.
//   BCD ADD a=45 b=38 cin=0 -> result=83 carry=0; a=99 b=01 -> result=00 carry=1 zero=1.
//   SHL a=81 cin=0 -> result=02 carry=1; ROR a=01 -> result=80 carry=1; MUX a=F0 b=0F c=3C -> CC.
//   Set rst=1 in the middle of a random stream (reserved bits toggling) -> next cycle all 0;
//   random vectors vs gate-level twin -> outputs bit-identical every cycle.

Source files
------------

// File: rtl/c3540_alu_core_if.sv
// c3540_alu_core bus: flat 50-bit operand/control vector in,
// 22-bit registered result/flag vector out.
interface c3540_alu_core_if;
  logic [49:0] in_vec;
  logic [21:0] out_vec;

  modport master (
    output in_vec,
    input  out_vec
  );

  modport slave (
    input  in_vec,
    output out_vec
  );
endinterface

// File: rtl/c3540_alu_core.sv
// c3540_alu_core: 8-bit binary/BCD ALU with equality datapath,
// combinational decode into a single 22-bit output register.
module c3540_alu_core (
  input  logic clk,
  input  logic rst,
  c3540_alu_core_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,
    OP_INC  = 4'd2,  OP_DEC  = 4'd3,
    OP_AND  = 4'd4,  OP_OR   = 4'd5,
    OP_XOR  = 4'd6,  OP_NOT  = 4'd7,
    OP_SHL  = 4'd8,  OP_SHR  = 4'd9,
    OP_ROL  = 4'd10, OP_ROR  = 4'd11,
    OP_PSA  = 4'd12, OP_PSB  = 4'd13,
    OP_MUX  = 4'd14, OP_CMP  = 4'd15
  } op_e;

  logic [7:0]  a, b, c;
  op_e         op;
  logic        cin, bcd, en;

  assign a   = bus.in_vec[7:0];
  assign b   = bus.in_vec[15:8];
  assign c   = bus.in_vec[23:16];
  assign op  = op_e'(bus.in_vec[27:24]);
  assign cin = bus.in_vec[28];
  assign bcd = bus.in_vec[29];
  assign en  = bus.in_vec[30];

  // Decimal digit add: returns {carry, digit}.
  function automatic logic [4:0] bcd_dig(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       ci
  );
    logic [5:0] s;
    s = {2'b00, x} + {2'b00, y} + {5'b0, ci};
    if (s > 6'd9) return {1'b1, s[3:0] + 4'd6};
    return {1'b0, s[3:0]};
  endfunction

  // Nine's complement of one digit; invalid digits map to 0.
  function automatic logic [3:0] nine(input logic [3:0] n);
    return (n > 4'd9) ? 4'd0 : 4'd9 - n;
  endfunction

  logic [7:0]  y;
  logic        ci;
  logic [8:0]  sum;
  logic        sovf;
  logic [7:0]  bb;
  logic [4:0]  dlo, dhi;
  logic [7:0]  res;
  logic        cy, ov, zr, sg;
  logic [21:0] out_d, out_q;

  // Shared binary adder: pick second addend and carry-in per op.
  always_comb begin
    y  = b;
    ci = cin;
    unique case (op)
      OP_SUB:  y  = ~b;
      OP_INC:  begin y = 8'h00; ci = 1'b1; end
      OP_DEC:  begin y = 8'hFF; ci = 1'b0; end
      OP_CMP:  begin y = ~b;    ci = 1'b1; end
      default: ;
    endcase
  end

  assign sum  = {1'b0, a} + {1'b0, y} + {8'b0, ci};
  assign sovf = (a[7] == y[7]) & (sum[7] != a[7]);

  assign bb  = (op == OP_SUB) ? {nine(b[7:4]), nine(b[3:0])} : b;
  assign dlo = bcd_dig(a[3:0], bb[3:0], cin);
  assign dhi = bcd_dig(a[7:4], bb[7:4], dlo[4]);

  // Result and flag selection for the output register.
  always_comb begin
    res = a;
    cy  = 1'b0;
    ov  = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        if (bcd) begin
          res = {dhi[3:0], dlo[3:0]};
          cy  = dhi[4];
        end else begin
          res = sum[7:0];
          cy  = sum[8];
          ov  = sovf;
        end
      end
      OP_INC, OP_DEC: begin
        res = sum[7:0];
        cy  = sum[8];
        ov  = sovf;
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: begin res = {a[6:0], cin};  cy = a[7]; end
      OP_SHR: begin res = {cin, a[7:1]};  cy = a[0]; end
      OP_ROL: begin res = {a[6:0], a[7]}; cy = a[7]; end
      OP_ROR: begin res = {a[0], a[7:1]}; cy = a[0]; end
      OP_PSA: res = a;
      OP_PSB: res = b;
      OP_MUX: res = (c & b) | (~c & a);
      OP_CMP: begin
        res = a;
        cy  = sum[8];
        ov  = sovf;
      end
      default: ;
    endcase
    zr = (op == OP_CMP) ? (a == b) : (res == 8'h00);
    sg = (op == OP_CMP) ? sum[7] : res[7];
    out_d = {(a == b), ^res, ov, sg, zr, cy, ~(a ^ b), res};
  end

  // Output register: reset wins, en=0 holds.
  always_ff @(posedge clk) begin
    if (rst)     out_q <= 22'h0;
    else if (en) out_q <= out_d;
  end

  assign bus.out_vec = out_q;

endmodule

// File: tb/tb_c3540_alu_core.sv
// Directed self-checking bench for c3540_alu_core.
// Expected values are hand-computed constants.
module tb_c3540_alu_core;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  c3540_alu_core_if bus ();

  c3540_alu_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [21:0] got,
    input logic [21:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] pk(
    input logic [7:0] r, input logic [7:0] m,
    input logic cy, input logic zr, input logic sg,
    input logic ov, input logic pr, input logic eq
  );
    return {eq, pr, ov, sg, zr, cy, m, r};
  endfunction

  // Drive one vector at negedge, sample 1 time unit after posedge.
  task automatic apply(
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] c, input logic [3:0] op,
    input logic cin, input logic bcd, input logic en
  );
    logic [18:0] rsv;
    @(negedge clk);
    rsv = 19'($urandom);
    bus.in_vec = {rsv, en, bcd, cin, op, c, b, a};
    @(posedge clk);
    #1;
  endtask

  logic [21:0] last;
  logic [7:0]  ra, rb;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", bus.out_vec, 22'h0);
    rst = 1'b0;
    apply(8'h12, 8'h34, 8'h56, 4'd0, 1'b1, 1'b0, 1'b0);
    check("en0_after_rst", bus.out_vec, 22'h0);
    apply(8'hFF, 8'h00, 8'h00, 4'd5, 1'b0, 1'b0, 1'b0);
    check("en0_hold0", bus.out_vec, 22'h0);

    apply(8'h7F, 8'h01, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
    check("add_ovf", bus.out_vec,
          pk(8'h80, 8'h81, 0, 0, 1, 1, 1, 0));
    apply(8'h10, 8'h10, 8'h00, 4'd1, 1'b1, 1'b0, 1'b1);
    check("sub_eq", bus.out_vec,
          pk(8'h00, 8'hFF, 1, 1, 0, 0, 0, 1));
    apply(8'h45, 8'h38, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    check("bcd_add", bus.out_vec,
          pk(8'h83, 8'h82, 0, 0, 1, 0, 1, 0));
    apply(8'h99, 8'h01, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    check("bcd_add_wrap", bus.out_vec,
          pk(8'h00, 8'h67, 1, 1, 0, 0, 0, 0));
    apply(8'h52, 8'h17, 8'h00, 4'd1, 1'b1, 1'b1, 1'b1);
    check("bcd_sub", bus.out_vec,
          pk(8'h35, 8'hBA, 1, 0, 0, 0, 0, 0));
    apply(8'h81, 8'h00, 8'h00, 4'd8, 1'b0, 1'b0, 1'b1);
    check("shl", bus.out_vec,
          pk(8'h02, 8'h7E, 1, 0, 0, 0, 1, 0));
    apply(8'h01, 8'h00, 8'h00, 4'd9, 1'b1, 1'b0, 1'b1);
    check("shr_cin", bus.out_vec,
          pk(8'h80, 8'hFE, 1, 0, 1, 0, 1, 0));
    apply(8'h80, 8'h80, 8'h00, 4'd10, 1'b0, 1'b0, 1'b1);
    check("rol", bus.out_vec,
          pk(8'h01, 8'hFF, 1, 0, 0, 0, 1, 1));
    apply(8'h01, 8'h01, 8'h00, 4'd11, 1'b0, 1'b0, 1'b1);
    check("ror", bus.out_vec,
          pk(8'h80, 8'hFF, 1, 0, 1, 0, 1, 1));
    apply(8'hF0, 8'h0F, 8'h3C, 4'd14, 1'b0, 1'b0, 1'b1);
    check("mux", bus.out_vec,
          pk(8'hCC, 8'h00, 0, 0, 1, 0, 0, 0));
    apply(8'h05, 8'h07, 8'h00, 4'd15, 1'b0, 1'b0, 1'b1);
    check("cmp_lt", bus.out_vec,
          pk(8'h05, 8'hFD, 0, 0, 1, 0, 0, 0));
    apply(8'h80, 8'h01, 8'h00, 4'd15, 1'b0, 1'b0, 1'b1);
    check("cmp_ovf", bus.out_vec,
          pk(8'h80, 8'h7E, 1, 0, 0, 1, 1, 0));
    apply(8'h00, 8'h00, 8'h00, 4'd3, 1'b1, 1'b0, 1'b1);
    check("dec_zero", bus.out_vec,
          pk(8'hFF, 8'hFF, 0, 0, 1, 0, 0, 1));
    apply(8'hFF, 8'h00, 8'h00, 4'd2, 1'b0, 1'b0, 1'b1);
    check("inc_wrap", bus.out_vec,
          pk(8'h00, 8'h00, 1, 1, 0, 0, 0, 0));
    apply(8'h3C, 8'h3C, 8'h00, 4'd7, 1'b1, 1'b0, 1'b1);
    check("not", bus.out_vec,
          pk(8'hC3, 8'hFF, 0, 0, 1, 0, 0, 1));
    apply(8'hAA, 8'h0F, 8'h00, 4'd6, 1'b1, 1'b1, 1'b1);
    check("xor_bcd_ign", bus.out_vec,
          pk(8'hA5, 8'h5A, 0, 0, 1, 0, 0, 0));
    last = pk(8'hA5, 8'h5A, 0, 0, 1, 0, 0, 0);
    apply(8'h00, 8'h00, 8'hFF, 4'd13, 1'b0, 1'b0, 1'b0);
    check("en0_hold", bus.out_vec, last);

    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom);
      rb = (i % 3 == 0) ? ra : 8'($urandom);
      apply(ra, rb, 8'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'b1);
      check("rnd_eqmask", {14'h0, bus.out_vec[15:8]},
            {14'h0, ~(ra ^ rb)});
      check("rnd_eq", {21'h0, bus.out_vec[21]},
            {21'h0, ra == rb});
    end
    @(negedge clk);
    rst = 1'b1;
    apply(8'h7F, 8'h01, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
    check("mid_reset", bus.out_vec, 22'h0);
    rst = 1'b0;
    apply(8'h81, 8'h00, 8'h00, 4'd8, 1'b0, 1'b0, 1'b1);
    check("post_reset_shl", bus.out_vec,
          pk(8'h02, 8'h7E, 1, 0, 0, 0, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
